// File: rtl/jtag_confreg_bridge.sv
// Bridges the TCK-domain config register and FLL select into the SoC clock domain.
// Adds a glitch filter, a change-event handshake and a SoC-writable readback register.
module jtag_confreg_bridge #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [8:0]  RESET_VALUE   = 9'h000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] jtag_reg_async_i,
    input  logic       jtag_fll_sel_async_i,
    output logic [7:0] reg_value_o,
    output logic       fll_sel_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [8:0] evt_data_o,
    output logic       evt_overrun_o,
    input  logic       overrun_clr_i,
    input  logic       soc_wr_en_i,
    input  logic [7:0] soc_wr_data_i,
    output logic [7:0] soc_jtag_reg_o
);

    localparam int unsigned WORD_W = 9;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   sync_ff [SYNC_STAGES];
    logic [WORD_W-1:0]   sync_q;
    logic [WORD_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   committed_q;
    logic                commit_c;
    logic                overrun_set_c;
    logic                evt_valid_q;
    logic [WORD_W-1:0]   evt_data_q;
    logic                evt_overrun_q;
    logic [7:0]          soc_reg_q;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Multi-stage synchronizer on all nine asynchronous bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= RESET_VALUE;
            end
        end else begin
            sync_ff[0] <= {jtag_fll_sel_async_i, jtag_reg_async_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    // Filter next-state: a value must be seen STABLE_CYCLES times in a row to commit.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_q != committed_q) begin
                    cand_d  = sync_q;
                    cnt_d   = CNT_W'(1);
                    state_d = QUAL;
                end
            end
            QUAL: begin
                if (sync_q != cand_q) begin
                    if (sync_q == committed_q) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = sync_q;
                        cnt_d  = CNT_W'(1);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    commit_c = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cand_q      <= RESET_VALUE;
            cnt_q       <= '0;
            committed_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (commit_c) begin
                committed_q <= cand_q;
            end
        end
    end

    // Overwriting an unaccepted event is the only overrun source.
    assign overrun_set_c = commit_c & evt_valid_q & ~evt_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_valid_q   <= 1'b0;
            evt_data_q    <= RESET_VALUE;
            evt_overrun_q <= 1'b0;
        end else begin
            if (commit_c) begin
                evt_valid_q <= 1'b1;
                evt_data_q  <= cand_q;
            end else if (evt_valid_q && evt_ready_i) begin
                evt_valid_q <= 1'b0;
            end
            if (overrun_set_c) begin
                evt_overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                evt_overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            soc_reg_q <= RESET_VALUE[7:0];
        end else if (soc_wr_en_i) begin
            soc_reg_q <= soc_wr_data_i;
        end
    end

    assign reg_value_o    = committed_q[7:0];
    assign fll_sel_o      = committed_q[8];
    assign evt_valid_o    = evt_valid_q;
    assign evt_data_o     = evt_data_q;
    assign evt_overrun_o  = evt_overrun_q;
    assign soc_jtag_reg_o = soc_reg_q;

endmodule

// File: tb/tb_jtag_confreg_bridge.sv
// Self-checking bench for jtag_confreg_bridge: directed scenarios plus randomized
// traffic compared against a run-length reference model of the filter and event queue.
module tb_jtag_confreg_bridge;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;
    localparam logic [8:0]  RV     = 9'h000;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] jtag_reg_async_i = 8'h00;
    logic       jtag_fll_sel_async_i = 1'b0;
    logic [7:0] reg_value_o;
    logic       fll_sel_o;
    logic       evt_valid_o;
    logic       evt_ready_i = 1'b0;
    logic [8:0] evt_data_o;
    logic       evt_overrun_o;
    logic       overrun_clr_i = 1'b0;
    logic       soc_wr_en_i = 1'b0;
    logic [7:0] soc_wr_data_i = 8'h00;
    logic [7:0] soc_jtag_reg_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtag_confreg_bridge #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .RESET_VALUE  (RV)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .jtag_reg_async_i    (jtag_reg_async_i),
        .jtag_fll_sel_async_i(jtag_fll_sel_async_i),
        .reg_value_o         (reg_value_o),
        .fll_sel_o           (fll_sel_o),
        .evt_valid_o         (evt_valid_o),
        .evt_ready_i         (evt_ready_i),
        .evt_data_o          (evt_data_o),
        .evt_overrun_o       (evt_overrun_o),
        .overrun_clr_i       (overrun_clr_i),
        .soc_wr_en_i         (soc_wr_en_i),
        .soc_wr_data_i       (soc_wr_data_i),
        .soc_jtag_reg_o      (soc_jtag_reg_o)
    );

    // Reference model: inputs delayed SYNC edges, then committed once a value
    // differing from the committed word has been observed STABLE times in a row.
    logic [8:0] m_hist [$];
    logic [8:0] m_run_val;
    int         m_run_len;
    logic [8:0] m_comm;
    logic       m_valid;
    logic [8:0] m_data;
    logic       m_ovr;
    logic [7:0] m_soc;

    initial begin
        logic [8:0] obs;
        logic       commit;
        logic       set_ovr;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                m_hist.delete();
                for (int i = 0; i < SYNC; i++) m_hist.push_back(RV);
                m_run_val = RV;
                m_run_len = 0;
                m_comm    = RV;
                m_valid   = 1'b0;
                m_data    = RV;
                m_ovr     = 1'b0;
                m_soc     = RV[7:0];
            end else begin
                obs = m_hist.pop_front();
                m_hist.push_back({jtag_fll_sel_async_i, jtag_reg_async_i});
                if (obs == m_run_val) begin
                    if (m_run_len < 1000) m_run_len++;
                end else begin
                    m_run_val = obs;
                    m_run_len = 1;
                end
                commit  = (obs != m_comm) && (m_run_len >= STABLE);
                set_ovr = commit && m_valid && !evt_ready_i;
                if (commit) begin
                    m_valid = 1'b1;
                    m_data  = obs;
                    m_comm  = obs;
                end else if (m_valid && evt_ready_i) begin
                    m_valid = 1'b0;
                end
                if (set_ovr) m_ovr = 1'b1;
                else if (overrun_clr_i) m_ovr = 1'b0;
                if (soc_wr_en_i) m_soc = soc_wr_data_i;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        jtag_reg_async_i = 8'h00;
        jtag_fll_sel_async_i = 1'b0;
        evt_ready_i = 1'b0;
        overrun_clr_i = 1'b0;
        soc_wr_en_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        soc_wr_en_i = 1'b1;
        soc_wr_data_i = 8'h33;
        tick(1);
        soc_wr_en_i = 1'b0;
        do_reset();
        n_vec++; if (reg_value_o !== 8'h00) begin n_err++; $display("FAIL reset_reg got %h exp 00", reg_value_o); end
        n_vec++; if (fll_sel_o !== 1'b0) begin n_err++; $display("FAIL reset_fll got %b exp 0", fll_sel_o); end
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", evt_valid_o); end
        n_vec++; if (evt_overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_ovr got %b exp 0", evt_overrun_o); end
        n_vec++; if (soc_jtag_reg_o !== 8'h00) begin n_err++; $display("FAIL reset_soc got %h exp 00", soc_jtag_reg_o); end
    endtask

    task automatic test_commit();
        do_reset();
        jtag_reg_async_i = 8'hA5;
        tick(5);
        n_vec++; if (reg_value_o !== 8'h00) begin n_err++; $display("FAIL commit_early got %h exp 00", reg_value_o); end
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL commit_early_valid got %b exp 0", evt_valid_o); end
        tick(1);
        n_vec++; if (reg_value_o !== 8'hA5) begin n_err++; $display("FAIL commit_reg got %h exp a5", reg_value_o); end
        n_vec++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL commit_valid got %b exp 1", evt_valid_o); end
        n_vec++; if (evt_data_o !== 9'h0A5) begin n_err++; $display("FAIL commit_data got %h exp 0a5", evt_data_o); end
        tick(3);
        n_vec++; if (evt_valid_o !== 1'b1 || evt_data_o !== 9'h0A5) begin n_err++; $display("FAIL commit_hold got %b/%h exp 1/0a5", evt_valid_o, evt_data_o); end
        evt_ready_i = 1'b1;
        tick(1);
        evt_ready_i = 1'b0;
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL commit_accept got %b exp 0", evt_valid_o); end
    endtask

    task automatic test_glitch();
        do_reset();
        jtag_reg_async_i = 8'h3C;
        tick(2);
        jtag_reg_async_i = 8'h00;
        tick(10);
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %b exp 0", evt_valid_o); end
        n_vec++; if (reg_value_o !== 8'h00) begin n_err++; $display("FAIL glitch_reg got %h exp 00", reg_value_o); end
    endtask

    task automatic test_overrun();
        do_reset();
        jtag_reg_async_i = 8'h11;
        tick(6);
        jtag_reg_async_i = 8'h22;
        tick(6);
        n_vec++; if (evt_data_o !== 9'h022) begin n_err++; $display("FAIL ovr_data got %h exp 022", evt_data_o); end
        n_vec++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b exp 1", evt_valid_o); end
        n_vec++; if (evt_overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_set got %b exp 1", evt_overrun_o); end
        overrun_clr_i = 1'b1;
        tick(1);
        overrun_clr_i = 1'b0;
        n_vec++; if (evt_overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_clr got %b exp 0", evt_overrun_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        jtag_reg_async_i = 8'h11;
        tick(6);
        jtag_reg_async_i = 8'h55;
        tick(5);
        n_vec++; if (evt_data_o !== 9'h011 || evt_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_pending got %b/%h exp 1/011", evt_valid_o, evt_data_o); end
        evt_ready_i = 1'b1;
        tick(1);
        n_vec++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b exp 1", evt_valid_o); end
        n_vec++; if (evt_data_o !== 9'h055) begin n_err++; $display("FAIL b2b_data got %h exp 055", evt_data_o); end
        n_vec++; if (evt_overrun_o !== 1'b0) begin n_err++; $display("FAIL b2b_ovr got %b exp 0", evt_overrun_o); end
        tick(1);
        evt_ready_i = 1'b0;
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", evt_valid_o); end
    endtask

    task automatic test_fll_and_soc();
        do_reset();
        jtag_fll_sel_async_i = 1'b1;
        tick(5);
        n_vec++; if (fll_sel_o !== 1'b0) begin n_err++; $display("FAIL fll_early got %b exp 0", fll_sel_o); end
        tick(1);
        n_vec++; if (fll_sel_o !== 1'b1) begin n_err++; $display("FAIL fll_sel got %b exp 1", fll_sel_o); end
        n_vec++; if (evt_data_o !== 9'h100) begin n_err++; $display("FAIL fll_data got %h exp 100", evt_data_o); end
        soc_wr_en_i = 1'b1;
        soc_wr_data_i = 8'h7E;
        tick(1);
        soc_wr_en_i = 1'b0;
        soc_wr_data_i = 8'h12;
        n_vec++; if (soc_jtag_reg_o !== 8'h7E) begin n_err++; $display("FAIL soc_wr got %h exp 7e", soc_jtag_reg_o); end
        tick(2);
        n_vec++; if (soc_jtag_reg_o !== 8'h7E) begin n_err++; $display("FAIL soc_hold got %h exp 7e", soc_jtag_reg_o); end
    endtask

    task automatic test_reset_midqual();
        do_reset();
        jtag_reg_async_i = 8'h11;
        tick(6);
        jtag_reg_async_i = 8'h22;
        tick(4);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        n_vec++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL rstq_valid got %b exp 0", evt_valid_o); end
        n_vec++; if (reg_value_o !== 8'h00) begin n_err++; $display("FAIL rstq_reg got %h exp 00", reg_value_o); end
        tick(5);
        n_vec++; if (reg_value_o !== 8'h00) begin n_err++; $display("FAIL rstq_early got %h exp 00", reg_value_o); end
        tick(1);
        n_vec++; if (reg_value_o !== 8'h22) begin n_err++; $display("FAIL rstq_recommit got %h exp 22", reg_value_o); end
    endtask

    task automatic test_random();
        logic [8:0] vals [4];
        int hold;
        vals[0] = 9'h000; vals[1] = 9'h0A5; vals[2] = 9'h15A; vals[3] = 9'h1FF;
        hold = 0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            n_vec++; if (reg_value_o !== m_comm[7:0]) begin n_err++; $display("FAIL rand_reg cyc=%0d got %h exp %h", cyc, reg_value_o, m_comm[7:0]); end
            n_vec++; if (fll_sel_o !== m_comm[8]) begin n_err++; $display("FAIL rand_fll cyc=%0d got %b exp %b", cyc, fll_sel_o, m_comm[8]); end
            n_vec++; if (evt_valid_o !== m_valid) begin n_err++; $display("FAIL rand_valid cyc=%0d got %b exp %b", cyc, evt_valid_o, m_valid); end
            n_vec++; if (m_valid && evt_data_o !== m_data) begin n_err++; $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, evt_data_o, m_data); end
            n_vec++; if (evt_overrun_o !== m_ovr) begin n_err++; $display("FAIL rand_ovr cyc=%0d got %b exp %b", cyc, evt_overrun_o, m_ovr); end
            n_vec++; if (soc_jtag_reg_o !== m_soc) begin n_err++; $display("FAIL rand_soc cyc=%0d got %h exp %h", cyc, soc_jtag_reg_o, m_soc); end
            if (hold == 0) begin
                {jtag_fll_sel_async_i, jtag_reg_async_i} = vals[$urandom_range(0, 3)];
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            evt_ready_i   = ($urandom_range(0, 3) == 0);
            overrun_clr_i = ($urandom_range(0, 15) == 0);
            soc_wr_en_i   = ($urandom_range(0, 7) == 0);
            soc_wr_data_i = 8'($urandom);
            rst_i         = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst_i = 1'b0;
    endtask

    initial begin
        tick(2);
        test_reset();
        test_commit();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_fll_and_soc();
        test_reset_midqual();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_confreg_bridge.md
JTAG_CONFREG_BRIDGE -- requirements
Module: jtag_confreg_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on the TCK-domain inputs; legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 4, sets the consecutive equal synchronized samples required before commit; legal range 2..255.
REQ-003 Parameter RESET_VALUE, 9 bits, default 9'h000, sets the committed value after reset: bit 8 is FLL select, bits 7:0 are the SoC register.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk_i, input, 1 bit: SoC clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 Port jtag_reg_async_i, input, 8 bits: TCK-domain config register bits 7:0, asynchronous to clk_i.
REQ-008 Port jtag_fll_sel_async_i, input, 1 bit: TCK-domain FLL-select bit, asynchronous to clk_i.
REQ-009 Port reg_value_o, output, 8 bits: committed, filtered register value.
REQ-010 Port fll_sel_o, output, 1 bit: committed FLL select.
REQ-011 Port evt_valid_o, output, 1 bit: change event pending.
REQ-012 Port evt_ready_i, input, 1 bit: consumer accepts the event.
REQ-013 Port evt_data_o, output, 9 bits: committed word {fll_sel, reg[7:0]} belonging to the pending event.
REQ-014 Port evt_overrun_o, output, 1 bit: sticky flag, set when a pending event was overwritten.
REQ-015 Port overrun_clr_i, input, 1 bit: clears evt_overrun_o.
REQ-016 Port soc_wr_en_i, input, 1 bit: SoC write strobe for the readback register.
REQ-017 Port soc_wr_data_i, input, 8 bits: SoC write data.
REQ-018 Port soc_jtag_reg_o, output, 8 bits: readback register driven to the TCK domain for DR capture.

Function
REQ-019 The block SHALL synchronize all 9 async bits through SYNC_STAGES flops each; the last stage is sync_q.
REQ-020 The filter FSM SHALL have two states: IDLE and QUAL; it holds a 9-bit candidate cand and an 8-bit counter cnt.
REQ-021 In IDLE, when sync_q != committed, the FSM SHALL load cand<=sync_q and cnt<=1, and go to QUAL; otherwise it stays in IDLE.
REQ-022 In QUAL, when sync_q != cand and sync_q == committed, the FSM SHALL return to IDLE with no commit (glitch rejected).
REQ-023 In QUAL, when sync_q != cand and sync_q != committed, the FSM SHALL set cand<=sync_q and cnt<=1, and stay in QUAL (restart).
REQ-024 In QUAL, when sync_q == cand and cnt == STABLE_CYCLES-1, the FSM SHALL commit: committed<=cand, post an event, and go to IDLE.
REQ-025 In QUAL, when sync_q == cand and cnt < STABLE_CYCLES-1, the FSM SHALL increment cnt; cnt never wraps.
REQ-026 Latency: a stable input change SHALL appear on reg_value_o/fll_sel_o exactly SYNC_STAGES+STABLE_CYCLES clk_i edges after the first edge that samples it.
REQ-027 {fll_sel_o, reg_value_o} SHALL be the committed register, driven directly with no combinational path from the inputs.
REQ-028 Event posting: on commit, evt_valid_o SHALL be 1 and evt_data_o SHALL equal the committed word from the next cycle.
REQ-029 evt_valid_o and evt_data_o SHALL stay stable while evt_valid_o=1 and evt_ready_i=0, unless a new commit occurs.
REQ-030 A handshake SHALL complete when evt_valid_o=1 and evt_ready_i=1; evt_valid_o falls the next cycle if no commit happens in the same cycle.
REQ-031 A commit while evt_valid_o=1 and evt_ready_i=0 SHALL overwrite evt_data_o, keep evt_valid_o=1, and set evt_overrun_o=1.
REQ-032 A commit in the same cycle as a completing handshake SHALL load the new data, keep evt_valid_o=1, and leave evt_overrun_o unchanged.
REQ-033 overrun_clr_i SHALL clear evt_overrun_o; if a set condition occurs in the same cycle, set wins.
REQ-034 soc_jtag_reg_o SHALL load soc_wr_data_i on each cycle with soc_wr_en_i=1, and otherwise hold.
REQ-035 evt_ready_i SHALL be ignored while evt_valid_o=0.

Reset
REQ-036 With rst_i=1, all synchronizer flops, cand and committed SHALL load RESET_VALUE; the FSM goes to IDLE, cnt=0, evt_valid_o=0, evt_overrun_o=0, soc_jtag_reg_o=RESET_VALUE[7:0].
REQ-037 Reset asserted mid-QUAL or with an event pending SHALL discard the candidate and the event, with no commit.
REQ-038 After reset deasserts, an input already differing from RESET_VALUE SHALL commit after SYNC_STAGES+STABLE_CYCLES edges.

Verification
REQ-039 Defaults; set jtag_reg_async_i=8'hA5 and hold -> reg_value_o=8'hA5 6 edges later; evt_valid_o=1, evt_data_o=9'h0A5.
REQ-040 Input 8'h00->8'h3C for 2 cycles, then back to 8'h00 -> no commit, evt_valid_o stays 0, reg_value_o=8'h00.
REQ-041 evt_ready_i=0; commit 8'h11 then commit 8'h22 -> evt_data_o=9'h022, evt_overrun_o=1; pulse overrun_clr_i -> evt_overrun_o=0.
REQ-042 Commit 8'h55 coinciding with evt_ready_i=1 accepting 8'h11 -> evt_valid_o stays 1, evt_data_o=9'h055, no overrun.
REQ-043 Toggle only jtag_fll_sel_async_i to 1 -> fll_sel_o=1 after 6 edges, evt_data_o=9'h100; write soc_wr_data_i=8'h7E -> soc_jtag_reg_o=8'h7E the next cycle.
REQ-044 Assert rst_i in QUAL (cnt=2) with an event pending -> the next cycle shows evt_valid_o=0, reg_value_o=8'h00, FSM in IDLE.
